uart_tx: RTL and testbench

- UART transmitter, the transmit side of the project's 8N1-style serial link; the companion to the existing receiver.
- Accepts a byte over a single-cycle start handshake and serialises it on `tx`: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from an internal baud counter in the `clk` domain. There is no derived clock, so all logic runs on `clk`.
- Sits between the protocol-select/control logic and the board TX pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default line constants.
// Imported by the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS         = 8;
  localparam int DEFAULT_CLK_FREQ  = 50000000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, held at 0 while cleared.
// tick is high in the cycle the counter sits at its terminal count.
// The counter wraps to 0 on the terminal count, so consecutive bits abut exactly.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Free-running bit-period counter, cleared while the line is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// tx falls on the edge that accepts tx_start; the frame lasts (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// tx_start is ignored while busy, except on the final stop-bit edge, where it chains a new frame with no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_dat,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // 13 bits covers the default 5208; grow only for very slow baud rates.
  localparam int CNT_W = (CLKS_PER_BIT > 8191) ? $clog2(CLKS_PER_BIT) : 13;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        par_bit;
  logic        tick;
  logic        idle;
  logic        frame_end;
  logic        accept;

  assign idle      = (state == ST_IDLE);
  assign frame_end = (state == ST_STOP) && tick && (stop_idx == LAST_STOP);
  // A start request on the final stop edge is treated exactly like one seen in IDLE.
  assign accept    = tx_start && (idle || frame_end);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (idle),
    .enable(!idle),
    .tick  (tick)
  );

  // Frame sequencer; every output is registered so tx never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (accept) begin
        shreg   <= tx_dat;
        par_bit <= (^tx_dat) ^ (PARITY_ODD != 0);
        bit_idx <= '0;
        state   <= ST_START;
        tx_busy <= 1'b1;
        tx      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
          ST_START: if (tick) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
          ST_DATA: if (tick) begin
            if (bit_idx == LAST_BIT) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: if (tick) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
          ST_STOP: if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
              tx      <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances cover the parity/stop-bit variants at 16 clocks per bit.
// Expected line levels come from a frame-position model of the serial format.
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] dat [4];
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // d0: 8N1, d1: even parity, d2: odd parity, d3: two stop bits
  uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_dat(dat[0]), .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_dat(dat[1]), .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_dat(dat[2]), .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_dat(dat[3]), .tx(tx[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic int has_par(input int d);
    return (d == 1 || d == 2) ? 1 : 0;
  endfunction

  function automatic int n_stop(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return (9 + has_par(d) + n_stop(d)) * CPB;
  endfunction

  // Line level k cycles into a frame carrying byte b.
  function automatic logic exp_tx(input int d, input logic [7:0] b, input int k);
    int pos;
    int ones;
    pos  = k / CPB;
    ones = $countones(b);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (has_par(d) == 1 && pos == 9) return ((ones % 2) == 1) ^ (d == 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge on which start[d]/dat[d] were raised (or, when
  // accepted=1, at the first negedge of an already-chained frame).
  // rej>=0 pulses a competing start with 0xFF at that cycle offset.
  // hold keeps start high and presents nb for a zero-gap follow-on frame.
  task automatic run_frame(input int d, input logic [7:0] b, input int rej,
                           input bit hold, input logic [7:0] nb, input bit accepted);
    int len;
    len = frame_len(d);
    if (!accepted) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < len; k++) begin
      chk($sformatf("d%0d b%02h k%0d tx", d, b, k), {7'd0, tx[d]}, {7'd0, exp_tx(d, b, k)});
      chk($sformatf("d%0d b%02h k%0d busy", d, b, k), {7'd0, busy[d]}, 8'd1);
      chk($sformatf("d%0d b%02h k%0d done", d, b, k), {7'd0, done[d]}, {7'd0, (accepted && k == 0)});
      if (k == 0 && !hold) start[d] = 1'b0;
      if (rej >= 0 && k == rej) begin
        start[d] = 1'b1;
        dat[d]   = 8'hFF;
      end
      if (rej >= 0 && k == rej + 1) start[d] = 1'b0;
      if (hold && k == len - 1) dat[d] = nb;
      @(negedge clk);
    end
    chk($sformatf("d%0d b%02h end done", d, b), {7'd0, done[d]}, 8'd1);
    if (hold) begin
      chk($sformatf("d%0d b%02h chain busy", d, b), {7'd0, busy[d]}, 8'd1);
      chk($sformatf("d%0d b%02h chain tx", d, b), {7'd0, tx[d]}, 8'd0);
    end else begin
      chk($sformatf("d%0d b%02h end busy", d, b), {7'd0, busy[d]}, 8'd0);
      chk($sformatf("d%0d b%02h end tx", d, b), {7'd0, tx[d]}, 8'd1);
      @(negedge clk);
      chk($sformatf("d%0d b%02h done pulse", d, b), {7'd0, done[d]}, 8'd0);
    end
  endtask

  task automatic idle_check(input int d, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk($sformatf("d%0d idle k%0d tx", d, k), {7'd0, tx[d]}, 8'd1);
      chk($sformatf("d%0d idle k%0d busy", d, k), {7'd0, busy[d]}, 8'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rb;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d tx", i), {7'd0, tx[i]}, 8'd1);
      chk($sformatf("reset d%0d busy", i), {7'd0, busy[i]}, 8'd0);
      chk($sformatf("reset d%0d done", i), {7'd0, done[i]}, 8'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // single 8N1 frame
    start[0] = 1'b1; dat[0] = 8'hA5;
    run_frame(0, 8'hA5, -1, 1'b0, 8'h00, 1'b0);

    // even and odd parity on 0x07
    start[1] = 1'b1; dat[1] = 8'h07;
    run_frame(1, 8'h07, -1, 1'b0, 8'h00, 1'b0);
    start[2] = 1'b1; dat[2] = 8'h07;
    run_frame(2, 8'h07, -1, 1'b0, 8'h00, 1'b0);

    // two stop bits
    start[3] = 1'b1; dat[3] = 8'h00;
    run_frame(3, 8'h00, -1, 1'b0, 8'h00, 1'b0);

    // start request while busy is dropped
    start[0] = 1'b1; dat[0] = 8'h3C;
    run_frame(0, 8'h3C, 50, 1'b0, 8'h00, 1'b0);
    idle_check(0, 40);

    // back-to-back frames with start held high
    start[0] = 1'b1; dat[0] = 8'h55;
    run_frame(0, 8'h55, -1, 1'b1, 8'hAA, 1'b0);
    run_frame(0, 8'hAA, -1, 1'b0, 8'h00, 1'b1);
    idle_check(0, 5);

    // random bytes across every variant
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        rb = 8'($urandom_range(0, 255));
        start[d] = 1'b1; dat[d] = rb;
        run_frame(d, rb, -1, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    // reset in the middle of D3 aborts the frame without a clock edge
    start[0] = 1'b1; dat[0] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid d3 tx", {7'd0, tx[0]}, 8'd0);
    chk("mid d3 busy", {7'd0, busy[0]}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst tx", {7'd0, tx[0]}, 8'd1);
    chk("async rst busy", {7'd0, busy[0]}, 8'd0);
    chk("async rst done", {7'd0, done[0]}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(0, 3);
    start[0] = 1'b1; dat[0] = 8'h81;
    run_frame(0, 8'h81, -1, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
